// File: rtl/umi_pack_pkg.sv
// ---------------------------------------------------------------------------
// umi_pack_pkg
//   Shared definitions for the streaming UMI packer: command/header widths,
//   header field offsets, FSM state and merge-select encodings, and the
//   helper that assembles the 160-bit header (command word + addresses).
// ---------------------------------------------------------------------------
package umi_pack_pkg;

  localparam int UMI_CMD_W = 32;
  localparam int HDR_W     = 160;
  localparam int ADDR_W    = 64;

  localparam int OPC_LSB   = 0;
  localparam int OPC_W     = 8;
  localparam int SIZE_LSB  = 8;
  localparam int SIZE_W    = 4;
  localparam int USER_LSB  = 12;
  localparam int USER_W    = 20;
  localparam int DST_LSB   = UMI_CMD_W;
  localparam int SRC_LSB   = DST_LSB + ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HEAD  = 2'd1,
    BODY  = 2'd2,
    FLUSH = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SEL_HEAD  = 2'd0,
    SEL_BODY  = 2'd1,
    SEL_FLUSH = 2'd2
  } sel_e;

  function automatic logic [HDR_W-1:0] build_header(
    input logic [OPC_W-1:0]  opcode,
    input logic [SIZE_W-1:0] size,
    input logic [USER_W-1:0] user,
    input logic [ADDR_W-1:0] dstaddr,
    input logic [ADDR_W-1:0] srcaddr
  );
    logic [HDR_W-1:0] h;
    h = '0;
    h[OPC_LSB  +: OPC_W]  = opcode;
    h[SIZE_LSB +: SIZE_W] = size;
    h[USER_LSB +: USER_W] = user;
    h[DST_LSB  +: ADDR_W] = dstaddr;
    h[SRC_LSB  +: ADDR_W] = srcaddr;
    return h;
  endfunction

endpackage

// File: rtl/umi_pack_realign.sv
// ---------------------------------------------------------------------------
// umi_pack_realign
//   Residue register and beat merge mux. Every data word is split at HD:
//   its low HD bits go out on the current beat, its high 160 bits are held
//   and become the low part of the following beat.
// Ports
//   clk, reset  clock / async active-high reset
//   sel         beat shape: head, body or flush
//   nodata      head beat carries no data (data field zeroed)
//   load        capture word[PW-1:HD] into the residue
//   clear       zero the residue (end of train)
//   hdr         assembled 160-bit header
//   word        current input data word
//   beat        merged packet beat
// ---------------------------------------------------------------------------
module umi_pack_realign
  import umi_pack_pkg::*;
#(
  parameter int PW = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  sel_e             sel,
  input  logic             nodata,
  input  logic             load,
  input  logic             clear,
  input  logic [HDR_W-1:0] hdr,
  input  logic [PW-1:0]    word,
  output logic [PW-1:0]    beat
);

  localparam int HD = PW - HDR_W;

  logic [HDR_W-1:0] residue;
  logic [HD-1:0]    lo;

  assign lo = word[HD-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      residue <= '0;
    end else if (load) begin
      residue <= word[PW-1:HD];
    end else if (clear) begin
      residue <= '0;
    end
  end

  always_comb begin
    beat = {lo, residue};
    case (sel)
      SEL_HEAD:  beat = nodata ? {{HD{1'b0}}, hdr} : {lo, hdr};
      SEL_BODY:  beat = {lo, residue};
      SEL_FLUSH: beat = {{HD{1'b0}}, residue};
      default:   beat = {{HD{1'b0}}, residue};
    endcase
  end

endmodule

// File: rtl/umi_pack_stream.sv
// ---------------------------------------------------------------------------
// umi_pack_stream
//   Streaming UMI packer. Takes one command plus N PW-bit data words and
//   emits a packet train: a head beat (header + low part of word 0), N-1
//   body beats, and a flush beat carrying the final residue. Commands with
//   no data produce a single head beat. Data is passed straight through
//   (no buffering), so din and pkt handshakes are coupled combinationally.
//   Optional build macro UMI_PACK_STREAM_PERF_EN adds perf_cmds and
//   perf_stalls saturating counters.
// Ports
//   clk, reset                 clock / async active-high reset
//   req_*                      command channel (valid/ready)
//   din_valid/ready/data       data word channel
//   pkt_valid/ready/data       packet beat channel
//   pkt_burst                  high on every beat after the head
//   pkt_last                   high on the final beat of a command
//   perf_cmds, perf_stalls     (perf build only) completed commands and
//                              stalled beat cycles
// ---------------------------------------------------------------------------
module umi_pack_stream
  import umi_pack_pkg::*;
#(
  parameter int AW = 64,
  parameter int PW = 256,
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [7:0]    req_opcode,
  input  logic [3:0]    req_size,
  input  logic [19:0]   req_user,
  input  logic [AW-1:0] req_dstaddr,
  input  logic [AW-1:0] req_srcaddr,
  input  logic          req_nodata,
  input  logic [BW-1:0] req_words,
  input  logic          din_valid,
  output logic          din_ready,
  input  logic [PW-1:0] din_data,
  output logic          pkt_valid,
  input  logic          pkt_ready,
  output logic [PW-1:0] pkt_data,
  output logic          pkt_burst,
  output logic          pkt_last
`ifdef UMI_PACK_STREAM_PERF_EN
  ,
  output logic [31:0]   perf_cmds,
  output logic [31:0]   perf_stalls
`endif
);

  if (AW != ADDR_W) begin : g_bad_aw
    $error("umi_pack_stream: only AW=64 is supported");
  end
  if ((PW % 32) != 0 || PW < 224 || PW > 1024) begin : g_bad_pw
    $error("umi_pack_stream: PW must be a multiple of 32 in 224..1024");
  end

  state_e           state, state_nxt;
  sel_e             sel;
  logic [HDR_W-1:0] cmd_hdr;
  logic             cmd_nodata;
  logic [BW-1:0]    rem;
  logic             fire;
  logic             accept;
  logic             res_load;
  logic             res_clear;

  assign fire      = pkt_valid & pkt_ready;
  // Ready also during the cycle the last beat leaves, so a waiting command
  // is taken with no idle cycle between trains.
  assign req_ready = ~reset & ((state == IDLE) | (fire & pkt_last));
  assign accept    = req_valid & req_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = HEAD;
      end
      HEAD: begin
        if (fire) begin
          if (cmd_nodata)     state_nxt = accept ? HEAD : IDLE;
          else if (rem == '0) state_nxt = FLUSH;
          else                state_nxt = BODY;
        end
      end
      BODY: begin
        if (fire && rem == BW'(1)) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (fire) state_nxt = accept ? HEAD : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    pkt_valid = 1'b0;
    din_ready = 1'b0;
    pkt_burst = 1'b0;
    pkt_last  = 1'b0;
    sel       = SEL_FLUSH;
    case (state)
      HEAD: begin
        sel = SEL_HEAD;
        if (cmd_nodata) begin
          pkt_valid = 1'b1;
          pkt_last  = 1'b1;
        end else begin
          pkt_valid = din_valid;
          din_ready = pkt_ready;
        end
      end
      BODY: begin
        sel       = SEL_BODY;
        pkt_valid = din_valid;
        din_ready = pkt_ready;
        pkt_burst = 1'b1;
      end
      FLUSH: begin
        sel       = SEL_FLUSH;
        pkt_valid = 1'b1;
        pkt_burst = 1'b1;
        pkt_last  = 1'b1;
      end
      default: begin
        pkt_valid = 1'b0;
      end
    endcase
  end

  assign res_load  = fire & (((state == HEAD) & ~cmd_nodata) | (state == BODY));
  assign res_clear = fire & (state == FLUSH);

  // Command capture and remaining-word counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_hdr    <= '0;
      cmd_nodata <= 1'b0;
      rem        <= '0;
    end else if (accept) begin
      cmd_hdr    <= build_header(req_opcode, req_size, req_user, req_dstaddr, req_srcaddr);
      cmd_nodata <= req_nodata;
      rem        <= req_nodata ? '0 : (req_words - BW'(1));
    end else if (fire && state == BODY) begin
      rem        <= rem - BW'(1);
    end
  end

  umi_pack_realign #(.PW(PW)) u_realign (
    .clk    (clk),
    .reset  (reset),
    .sel    (sel),
    .nodata (cmd_nodata),
    .load   (res_load),
    .clear  (res_clear),
    .hdr    (cmd_hdr),
    .word   (din_data),
    .beat   (pkt_data)
  );

`ifdef UMI_PACK_STREAM_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cmds   <= '0;
      perf_stalls <= '0;
    end else begin
      if (fire && pkt_last && perf_cmds != '1) perf_cmds <= perf_cmds + 32'd1;
      if (pkt_valid && !pkt_ready && perf_stalls != '1) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

  // A data command must carry at least one word; zero would wrap the counter.
  a_words_nonzero: assert property (@(posedge clk) disable iff (reset)
    (req_valid && req_ready && !req_nodata) |-> (req_words != '0));

endmodule

// File: tb/tb_umi_pack_stream.sv
module tb_umi_pack_stream;
  localparam int AW = 64;
  localparam int PW = 256;
  localparam int BW = 8;
  localparam int HD = PW - 160;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [7:0]    req_opcode;
  logic [3:0]    req_size;
  logic [19:0]   req_user;
  logic [AW-1:0] req_dstaddr;
  logic [AW-1:0] req_srcaddr;
  logic          req_nodata;
  logic [BW-1:0] req_words;
  logic          din_valid;
  logic          din_ready;
  logic [PW-1:0] din_data;
  logic          pkt_valid;
  logic          pkt_ready;
  logic [PW-1:0] pkt_data;
  logic          pkt_burst;
  logic          pkt_last;
`ifdef UMI_PACK_STREAM_PERF_EN
  logic [31:0]   perf_cmds;
  logic [31:0]   perf_stalls;
`endif

  always #5 clk = ~clk;

  umi_pack_stream #(.AW(AW), .PW(PW), .BW(BW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_opcode  (req_opcode),
    .req_size    (req_size),
    .req_user    (req_user),
    .req_dstaddr (req_dstaddr),
    .req_srcaddr (req_srcaddr),
    .req_nodata  (req_nodata),
    .req_words   (req_words),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .din_data    (din_data),
    .pkt_valid   (pkt_valid),
    .pkt_ready   (pkt_ready),
    .pkt_data    (pkt_data),
    .pkt_burst   (pkt_burst),
    .pkt_last    (pkt_last)
`ifdef UMI_PACK_STREAM_PERF_EN
    ,
    .perf_cmds   (perf_cmds),
    .perf_stalls (perf_stalls)
`endif
  );

  typedef struct {
    logic [7:0]  opc;
    logic [3:0]  size;
    logic [19:0] user;
    logic [63:0] dst;
    logic [63:0] src;
    logic        nodata;
    int          n;
  } cmd_t;

  typedef struct {
    logic [PW-1:0] data;
    logic          burst;
    logic          last;
  } beat_t;

  cmd_t          req_q[$];
  logic [PW-1:0] din_q[$];
  beat_t         exp_q[$];
  logic [PW-1:0] wbuf[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int stall_cnt = 0;
  int last_cyc = -1;
  int max_gap = 0;

  function automatic logic [PW-1:0] rand_word();
    logic [PW-1:0] w;
    for (int i = 0; i < PW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Reference model: a command becomes a list of expected beats. Word k's low
  // HD bits ride on beat k, its high 160 bits on beat k+1.
  task automatic add_cmd(input logic [7:0] opc, input logic [3:0] size, input logic [19:0] user,
                         input logic [63:0] dst, input logic [63:0] src, input logic nodata);
    cmd_t c;
    beat_t b;
    logic [159:0] hdr;
    logic [PW-1:0] w, wp;
    c.opc = opc; c.size = size; c.user = user; c.dst = dst; c.src = src;
    c.nodata = nodata; c.n = nodata ? 0 : wbuf.size();
    req_q.push_back(c);
    hdr = {src, dst, user, size, opc};
    if (nodata) begin
      b.data = {{HD{1'b0}}, hdr}; b.burst = 1'b0; b.last = 1'b1;
      exp_q.push_back(b);
    end else begin
      for (int i = 0; i < wbuf.size(); i++) din_q.push_back(wbuf[i]);
      w = wbuf[0];
      b.data = {w[HD-1:0], hdr}; b.burst = 1'b0; b.last = 1'b0;
      exp_q.push_back(b);
      for (int k = 1; k < wbuf.size(); k++) begin
        w = wbuf[k]; wp = wbuf[k-1];
        b.data = {w[HD-1:0], wp[PW-1:HD]}; b.burst = 1'b1; b.last = 1'b0;
        exp_q.push_back(b);
      end
      w = wbuf[wbuf.size()-1];
      b.data = {{HD{1'b0}}, w[PW-1:HD]}; b.burst = 1'b1; b.last = 1'b1;
      exp_q.push_back(b);
    end
    wbuf.delete();
  endtask

  task automatic add_rand_cmd(input logic nodata, input int n);
    for (int i = 0; i < n; i++) wbuf.push_back(rand_word());
    add_cmd(8'($urandom), 4'($urandom), 20'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, nodata);
  endtask

  // Runs all queued commands. abort_after>0 returns right after that many beats.
  task automatic drive(input int stall_pct, input int gap_pct, input int abort_after, input int max_cycles);
    int cycles = 0;
    int fires = 0;
    logic held = 1'b0;
    logic [PW-1:0] held_data;
    logic held_burst, held_last;
    logic din_hold = 1'b0;
    logic aborted = 1'b0;
    beat_t e;
    while (req_q.size() > 0 || din_q.size() > 0 || exp_q.size() > 0) begin
      if (cycles >= max_cycles) begin
        n_vec++; n_err++;
        $display("FAIL drive_timeout: %0d beats still expected after %0d cycles", exp_q.size(), cycles);
        break;
      end
      @(negedge clk);
      cycles++; cyc++;
      if (req_q.size() > 0) begin
        req_valid   = 1'b1;
        req_opcode  = req_q[0].opc;
        req_size    = req_q[0].size;
        req_user    = req_q[0].user;
        req_dstaddr = req_q[0].dst;
        req_srcaddr = req_q[0].src;
        req_nodata  = req_q[0].nodata;
        req_words   = req_q[0].nodata ? BW'($urandom) : BW'(req_q[0].n);
      end else begin
        req_valid = 1'b0;
      end
      if (din_q.size() > 0) begin
        din_valid = din_hold ? 1'b1 : ($urandom_range(99) >= gap_pct);
        din_data  = din_q[0];
      end else begin
        din_valid = 1'b0;
      end
      pkt_ready = ($urandom_range(99) >= stall_pct);
      #1;
      if (held) begin
        n_vec++;
        if (pkt_valid !== 1'b1 || pkt_data !== held_data || pkt_burst !== held_burst || pkt_last !== held_last) begin
          n_err++;
          $display("FAIL stall_hold: valid=%b data=%h got, held data=%h required", pkt_valid, pkt_data, held_data);
        end
      end
      held = 1'b0;
      if (pkt_valid && pkt_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL extra_beat: data=%h got, no beat expected", pkt_data);
        end else begin
          e = exp_q.pop_front();
          if (pkt_data !== e.data || pkt_burst !== e.burst || pkt_last !== e.last) begin
            n_err++;
            $display("FAIL beat: data=%h burst=%b last=%b got, data=%h burst=%b last=%b expected",
                     pkt_data, pkt_burst, pkt_last, e.data, e.burst, e.last);
          end
        end
        if (!pkt_burst && last_cyc >= 0 && (cyc - last_cyc) > max_gap) max_gap = cyc - last_cyc;
        if (pkt_last) last_cyc = cyc;
        fires++;
      end else if (pkt_valid) begin
        held = 1'b1; held_data = pkt_data; held_burst = pkt_burst; held_last = pkt_last;
        stall_cnt++;
      end
      din_hold = din_valid && !din_ready;
      if (din_valid && din_ready) void'(din_q.pop_front());
      if (req_valid && req_ready) void'(req_q.pop_front());
      if (abort_after > 0 && fires >= abort_after) begin
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0; din_valid = 1'b0; pkt_ready = 1'b1;
      #1;
      n_vec++;
      if (pkt_valid !== 1'b0 || req_ready !== 1'b1) begin
        n_err++;
        $display("FAIL idle_after: pkt_valid=%b req_ready=%b got, 0/1 required", pkt_valid, req_ready);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'b0; req_opcode = '0; req_size = '0; req_user = '0;
    req_dstaddr = '0; req_srcaddr = '0; req_nodata = 1'b0; req_words = '0;
    din_valid = 1'b0; din_data = '0; pkt_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_vec++;
    if (req_ready !== 1'b0 || pkt_valid !== 1'b0 || din_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: req_ready=%b pkt_valid=%b din_ready=%b got, all 0 required", req_ready, pkt_valid, din_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready: req_ready=%b got, 1 required", req_ready);
    end
    n_vec++;
    if (pkt_valid !== 1'b0 || din_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_idle: pkt_valid=%b din_ready=%b got, 0/0 required", pkt_valid, din_ready);
    end
`ifdef UMI_PACK_STREAM_PERF_EN
    n_vec++;
    if (perf_cmds !== 32'd0 || perf_stalls !== 32'd0) begin
      n_err++;
      $display("FAIL reset_perf: cmds=%0d stalls=%0d got, 0/0 required", perf_cmds, perf_stalls);
    end
`endif
  endtask

  task automatic test_nodata();
    add_cmd(8'h01, 4'h3, 20'h5A5A5, 64'h1122334455667788, 64'hAABBCCDDEEFF0011, 1'b1);
    drive(0, 0, 0, 100);
  endtask

  task automatic test_three_words();
    logic [PW-1:0] w;
    w = rand_word(); w[3:0] = 4'hA; wbuf.push_back(w);
    w = rand_word(); w[3:0] = 4'hB; wbuf.push_back(w);
    w = rand_word(); w[3:0] = 4'hC; wbuf.push_back(w);
    add_cmd(8'h05, 4'h5, 20'h00123, 64'h0000_1000_2000_3000, 64'h0000_0000_0000_4000, 1'b0);
    drive(0, 0, 0, 100);
  endtask

  task automatic test_stalls();
    logic [PW-1:0] words[4];
    int s0;
`ifdef UMI_PACK_STREAM_PERF_EN
    logic [31:0] pc0, ps0;
`endif
    for (int i = 0; i < 4; i++) words[i] = rand_word();
    for (int i = 0; i < 4; i++) wbuf.push_back(words[i]);
    add_cmd(8'h04, 4'h2, 20'h0BEEF, 64'hCAFE, 64'hF00D, 1'b0);
    drive(0, 0, 0, 100);
    s0 = stall_cnt;
`ifdef UMI_PACK_STREAM_PERF_EN
    pc0 = perf_cmds; ps0 = perf_stalls;
`endif
    for (int i = 0; i < 4; i++) wbuf.push_back(words[i]);
    add_cmd(8'h04, 4'h2, 20'h0BEEF, 64'hCAFE, 64'hF00D, 1'b0);
    drive(50, 30, 0, 400);
`ifdef UMI_PACK_STREAM_PERF_EN
    n_vec++;
    if (perf_stalls - ps0 !== 32'(stall_cnt - s0) || perf_cmds - pc0 !== 32'd1) begin
      n_err++;
      $display("FAIL perf_counts: stalls=%0d cmds=%0d got, stalls=%0d cmds=1 required",
               perf_stalls - ps0, perf_cmds - pc0, stall_cnt - s0);
    end
`else
    s0 = s0 + 0;
`endif
  endtask

  task automatic test_back_to_back();
    add_rand_cmd(1'b0, 2);
    add_rand_cmd(1'b1, 0);
    add_rand_cmd(1'b0, 1);
    add_rand_cmd(1'b1, 0);
    last_cyc = -1; max_gap = 0;
    drive(0, 0, 0, 100);
    n_vec++;
    if (max_gap !== 1) begin
      n_err++;
      $display("FAIL back_to_back_gap: head came %0d cycles after previous last, 1 required", max_gap);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(3) == 0) add_rand_cmd(1'b1, 0);
      else add_rand_cmd(1'b0, $urandom_range(1, 6));
    end
    drive(30, 20, 0, 2000);
  endtask

  task automatic test_reset_mid();
    add_rand_cmd(1'b0, 5);
    drive(0, 0, 2, 100);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_vec++;
    if (pkt_valid !== 1'b0 || din_ready !== 1'b0 || req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: pkt_valid=%b din_ready=%b req_ready=%b got, all 0 required", pkt_valid, din_ready, req_ready);
    end
    req_q.delete(); din_q.delete(); exp_q.delete();
    req_valid = 1'b0; din_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    add_rand_cmd(1'b0, 1);
    add_rand_cmd(1'b1, 0);
    add_rand_cmd(1'b0, 2);
    drive(0, 0, 0, 100);
  endtask

  initial begin
    test_reset();
    test_nodata();
    test_three_words();
    test_stalls();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
